// File: rtl/spi_cmd_queue.sv
`default_nettype none
// ==================================================================
// spi_cmd_queue : queued SPI master with settings bus and readback FIFO
// Revision: 1.0
// ==================================================================
module spi_cmd_queue #(
   parameter logic [7:0] SR_BASE    = 8'd168,
   parameter logic [7:0] RB_BASE    = 8'd24,
   parameter int         NUM_SEN    = 8,
   parameter int         DEPTH_LOG2 = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               set_stb,
   input  logic [7:0]         set_addr,
   input  logic [31:0]        set_data,
   input  logic               rb_rd,
   input  logic [7:0]         rb_addr,
   output logic               rb_stb,
   output logic [63:0]        rb_data,
   output logic [NUM_SEN-1:0] sen,
   output logic               sclk,
   output logic               mosi,
   input  logic               miso,
   output logic               rb_avail
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = 55 + NUM_SEN;
   localparam logic [7:0] A_DIV    = SR_BASE;
   localparam logic [7:0] A_CFG    = SR_BASE + 8'd1;
   localparam logic [7:0] A_PUSH   = SR_BASE + 8'd2;
   localparam logic [7:0] A_FLUSH  = SR_BASE + 8'd3;
   localparam logic [7:0] A_RBDATA = RB_BASE + 8'd1;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LEAD, S_TRAIL, S_HOLD, S_GAP} state_t;

   state_t               r_state;
   logic [15:0]          r_cfg_div;
   logic [5:0]           r_cfg_nbits;
   logic                 r_cfg_cpol;
   logic [NUM_SEN-1:0]   r_cfg_mask;
   logic [CW-1:0]        r_cmd_mem [DEPTH];
   logic [31:0]          r_rb_mem  [DEPTH];
   logic [DEPTH_LOG2:0]  r_cmd_wp, r_cmd_rp, r_rb_wp, r_rb_rp;
   logic                 r_cmd_ovf, r_rb_ovf, r_discard;
   logic [15:0]          r_div, r_tcnt;
   logic [5:0]           r_nbits, r_bitcnt;
   logic                 r_cpol;
   logic [31:0]          r_tx, r_rx;

   logic [DEPTH_LOG2:0]  w_cmd_cnt, w_rb_cnt;
   logic                 w_cmd_full, w_cmd_empty, w_rb_full, w_rb_empty;
   logic                 w_pop, w_push, w_push_ok, w_flush, w_tdone, w_rb_push, w_rb_pop, w_rb_push_ok;
   logic [CW-1:0]        w_cmd_head;
   logic [31:0]          w_hd_data, w_rb_head;
   logic [NUM_SEN-1:0]   w_hd_mask;
   logic [5:0]           w_hd_nbits, w_hd_neff;
   logic                 w_hd_cpol;
   logic [15:0]          w_hd_div;

   assign w_cmd_cnt   = r_cmd_wp - r_cmd_rp;
   assign w_rb_cnt    = r_rb_wp - r_rb_rp;
   assign w_cmd_full  = w_cmd_cnt[DEPTH_LOG2];
   assign w_rb_full   = w_rb_cnt[DEPTH_LOG2];
   assign w_cmd_empty = (w_cmd_cnt == '0);
   assign w_rb_empty  = (w_rb_cnt == '0);
   assign rb_avail    = !w_rb_empty;

   // Queue entry: {div, cpol, nbits, sen_mask, data}, snapshotted at push time
   assign w_cmd_head = r_cmd_mem[r_cmd_rp[DEPTH_LOG2-1:0]];
   assign w_hd_data  = w_cmd_head[31:0];
   assign w_hd_mask  = w_cmd_head[32 +: NUM_SEN];
   assign w_hd_nbits = w_cmd_head[32+NUM_SEN +: 6];
   assign w_hd_cpol  = w_cmd_head[38+NUM_SEN];
   assign w_hd_div   = w_cmd_head[39+NUM_SEN +: 16];
   assign w_hd_neff  = (w_hd_nbits == 6'd0 || w_hd_nbits > 6'd32) ? 6'd32 : w_hd_nbits;
   assign w_rb_head  = r_rb_mem[r_rb_rp[DEPTH_LOG2-1:0]];

   assign w_flush      = set_stb && (set_addr == A_FLUSH);
   assign w_push       = set_stb && (set_addr == A_PUSH);
   assign w_pop        = (r_state == S_IDLE) && !w_cmd_empty;
   assign w_push_ok    = w_push && (!w_cmd_full || w_pop);
   assign w_tdone      = (r_tcnt == r_div);
   assign w_rb_push    = (r_state == S_HOLD) && w_tdone && !r_discard && !w_flush;
   assign w_rb_pop     = rb_rd && (rb_addr == A_RBDATA) && !w_rb_empty;
   assign w_rb_push_ok = w_rb_push && (!w_rb_full || w_rb_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cfg_div   <= 16'd7;
         r_cfg_nbits <= 6'd0;
         r_cfg_cpol  <= 1'b0;
         r_cfg_mask  <= '0;
      end else if (set_stb) begin
         if (set_addr == A_DIV)
            r_cfg_div <= set_data[15:0];
         if (set_addr == A_CFG) begin
            r_cfg_nbits <= set_data[5:0];
            r_cfg_cpol  <= set_data[8];
            r_cfg_mask  <= set_data[16 +: NUM_SEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_cmd_mem[r_cmd_wp[DEPTH_LOG2-1:0]] <= {r_cfg_div, r_cfg_cpol, r_cfg_nbits, r_cfg_mask, set_data};
      if (w_rb_push_ok)
         r_rb_mem[r_rb_wp[DEPTH_LOG2-1:0]] <= r_rx;
   end

   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_cmd_ovf <= 1'b0;
         r_rb_wp   <= '0;
         r_rb_rp   <= '0;
         r_rb_ovf  <= 1'b0;
      end else begin
         if (w_pop)
            r_cmd_rp <= r_cmd_rp + PTR_ONE;
         if (w_push_ok)
            r_cmd_wp <= r_cmd_wp + PTR_ONE;
         else if (w_push)
            r_cmd_ovf <= 1'b1;
         if (w_rb_pop)
            r_rb_rp <= r_rb_rp + PTR_ONE;
         if (w_rb_push_ok)
            r_rb_wp <= r_rb_wp + PTR_ONE;
         else if (w_rb_push)
            r_rb_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         sen       <= '1;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         r_div     <= '0;
         r_nbits   <= '0;
         r_cpol    <= 1'b0;
         r_tcnt    <= '0;
         r_bitcnt  <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_discard <= 1'b0;
      end else begin
         if (r_state != S_IDLE)
            r_tcnt <= w_tdone ? 16'd0 : r_tcnt + 16'd1;
         case (r_state)
            S_IDLE: begin
               sclk <= r_cfg_cpol;
               if (w_pop) begin
                  r_div    <= w_hd_div;
                  r_nbits  <= w_hd_neff;
                  r_cpol   <= w_hd_cpol;
                  r_tx     <= {w_hd_data[30:0], 1'b0};
                  r_rx     <= '0;
                  r_tcnt   <= '0;
                  r_bitcnt <= '0;
                  sen      <= ~w_hd_mask;
                  sclk     <= w_hd_cpol;
                  mosi     <= w_hd_data[31];
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: if (w_tdone) begin
               sclk    <= ~r_cpol;
               r_state <= S_LEAD;
            end
            S_LEAD: begin
               if (r_tcnt == 16'd0)
                  r_rx <= {r_rx[30:0], miso};
               if (w_tdone) begin
                  sclk    <= r_cpol;
                  mosi    <= r_tx[31];
                  r_tx    <= {r_tx[30:0], 1'b0};
                  r_state <= S_TRAIL;
               end
            end
            S_TRAIL: if (w_tdone) begin
               if (r_bitcnt == r_nbits - 6'd1) begin
                  r_state <= S_HOLD;
               end else begin
                  r_bitcnt <= r_bitcnt + 6'd1;
                  sclk     <= ~r_cpol;
                  r_state  <= S_LEAD;
               end
            end
            S_HOLD: if (w_tdone) begin
               sen     <= '1;
               r_state <= S_GAP;
            end
            S_GAP: if (w_tdone)
               r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         // A flush while a command is on the wire lets it finish but drops its result
         if (w_flush && (r_state != S_IDLE || w_pop))
            r_discard <= 1'b1;
         else if (w_pop)
            r_discard <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rb_stb  <= 1'b0;
         rb_data <= '0;
      end else begin
         rb_stb <= rb_rd;
         if (rb_rd) begin
            if (rb_addr == RB_BASE)
               rb_data <= {32'd0, 13'd0, r_rb_ovf, r_cmd_ovf, (r_state != S_IDLE),
                           8'(w_rb_cnt), 8'(w_cmd_cnt)};
            else if (rb_addr == A_RBDATA)
               rb_data <= w_rb_empty ? 64'd0 : {31'd0, 1'b1, w_rb_head};
            else
               rb_data <= 64'h0BADC0DE0BADC0DE;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_queue.sv
`default_nettype none
// ==================================================================
// tb_spi_cmd_queue : directed self-checking bench for spi_cmd_queue
// Revision: 1.0
// ==================================================================
module tb_spi_cmd_queue;
   localparam logic [7:0] SR = 8'd168;
   localparam logic [7:0] RB = 8'd24;
   localparam int NS = 8;
   localparam int DL = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          set_stb = 1'b0;
   logic [7:0]    set_addr = 8'd0;
   logic [31:0]   set_data = 32'd0;
   logic          rb_rd = 1'b0;
   logic [7:0]    rb_addr = 8'd0;
   logic          rb_stb, sclk, mosi, miso, rb_avail;
   logic [63:0]   rb_data;
   logic [NS-1:0] sen;

   int errors = 0;
   int checks = 0;

   // Wire monitor state, sampled on the falling clock edge
   int tot_low = 0, sen0_low = 0, runs = 0, rises = 0, falls = 0, avail_hi = 0;
   int cur_high = 0, min_gap = 1000;
   logic seen_low = 1'b0, prev_low = 1'b0, prev_sclk = 1'b0;
   logic [63:0] mosi_rise = 64'd0;
   int s_tot, s_sen0, s_runs, s_rises, s_falls, s_avail;

   assign miso = mosi;

   spi_cmd_queue #(
      .SR_BASE(SR), .RB_BASE(RB), .NUM_SEN(NS), .DEPTH_LOG2(DL)
   ) dut (
      .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .rb_rd(rb_rd), .rb_addr(rb_addr), .rb_stb(rb_stb), .rb_data(rb_data),
      .sen(sen), .sclk(sclk), .mosi(mosi), .miso(miso), .rb_avail(rb_avail)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sen != '1) begin
         tot_low++;
         if (!prev_low) begin
            runs++;
            if (seen_low && cur_high < min_gap) min_gap = cur_high;
         end
         seen_low = 1'b1;
         cur_high = 0;
      end else begin
         cur_high++;
      end
      if (!sen[0]) sen0_low++;
      if (sclk && !prev_sclk) begin
         rises++;
         mosi_rise = {mosi_rise[62:0], mosi};
      end
      if (!sclk && prev_sclk) falls++;
      if (rb_avail) avail_hi++;
      prev_low  = (sen != '1);
      prev_sclk = sclk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      set_stb  = 1'b1;
      set_addr = addr;
      set_data = data;
      tick();
      set_stb  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [63:0] exp);
      rb_rd   = 1'b1;
      rb_addr = addr;
      tick();
      rb_rd   = 1'b0;
      rb_addr = 8'd0;
      chk({tag, "_stb"}, {63'd0, rb_stb}, 64'd1);
      chk(tag, rb_data, exp);
   endtask

   task automatic snap();
      s_tot = tot_low; s_sen0 = sen0_low; s_runs = runs;
      s_rises = rises; s_falls = falls; s_avail = avail_hi;
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_sen", 64'(sen), 64'hFF);
      chk("rst_sclk_mosi", {62'd0, sclk, mosi}, 64'd0);
      chk("rst_stb_avail", {62'd0, rb_stb, rb_avail}, 64'd0);
      chk("rst_rbdata", rb_data, 64'd0);
      reset = 1'b0;
      rd_chk("status_reset", RB, 64'd0);
      rd_chk("bad_addr", 8'd99, 64'h0BADC0DE0BADC0DE);
      rd_chk("pop_empty_init", RB + 8'd1, 64'd0);

      // Single 8-bit transfer, loopback
      wr(SR, 32'd0);
      wr(SR + 8'd1, 32'h0001_0008);
      snap();
      wr(SR + 8'd2, 32'hA500_0000);
      repeat (40) tick();
      chk("t1_sen0_low", 64'(sen0_low - s_sen0), 64'd18);
      chk("t1_runs", 64'(runs - s_runs), 64'd1);
      chk("t1_pulses", 64'(rises - s_rises), 64'd8);
      chk("t1_mosi", {56'd0, mosi_rise[7:0]}, 64'hA5);
      chk("t1_avail", {63'd0, rb_avail}, 64'd1);
      rd_chk("t1_status", RB, 64'h0000_0100);
      rd_chk("t1_pop", RB + 8'd1, 64'h1_0000_00A5);
      chk("t1_avail_after", {63'd0, rb_avail}, 64'd0);

      // Command overflow, then readback overflow from the fifth result
      wr(SR, 32'd3);
      wr(SR + 8'd1, 32'h0002_0002);
      snap();
      wr(SR + 8'd2, 32'hC000_0000);
      wr(SR + 8'd2, 32'h4000_0000);
      wr(SR + 8'd2, 32'h8000_0000);
      wr(SR + 8'd2, 32'h0000_0000);
      wr(SR + 8'd2, 32'hFFFF_FFFF);
      wr(SR + 8'd2, 32'h4000_0000);
      rd_chk("ovf_status_busy", RB, 64'h0003_0004);
      repeat (200) tick();
      chk("ovf_runs", 64'(runs - s_runs), 64'd5);
      chk("ovf_low_cycles", 64'(tot_low - s_tot), 64'd120);
      chk("ovf_pulses", 64'(rises - s_rises), 64'd10);
      chk("ovf_gap_ge4", {63'd0, (min_gap >= 4)}, 64'd1);
      rd_chk("ovf_status_done", RB, 64'h0006_0400);
      chk("ovf_avail", {63'd0, rb_avail}, 64'd1);
      rd_chk("ovf_pop0", RB + 8'd1, 64'h1_0000_0003);
      rd_chk("ovf_pop1", RB + 8'd1, 64'h1_0000_0001);
      rd_chk("ovf_pop2", RB + 8'd1, 64'h1_0000_0002);
      rd_chk("ovf_pop3", RB + 8'd1, 64'h1_0000_0000);
      tick();
      chk("stb_idle_before", {63'd0, rb_stb}, 64'd0);
      rd_chk("pop_empty", RB + 8'd1, 64'd0);
      tick();
      chk("stb_idle_after", {63'd0, rb_stb}, 64'd0);
      chk("ovf_avail_empty", {63'd0, rb_avail}, 64'd0);
      wr(SR + 8'd3, 32'd0);
      rd_chk("status_flushed", RB, 64'd0);

      // cpol = 1, 32-bit words, settings changed mid-transaction
      wr(SR, 32'd0);
      wr(SR + 8'd1, 32'h0001_0100);
      tick();
      tick();
      chk("cpol_idle_high", {63'd0, sclk}, 64'd1);
      snap();
      wr(SR + 8'd2, 32'h1234_5678);
      wr(SR + 8'd2, 32'h9ABC_DEF0);
      repeat (10) tick();
      wr(SR + 8'd1, 32'h0080_0104);
      wr(SR, 32'd5);
      repeat (200) tick();
      chk("cpol_falls", 64'(falls - s_falls), 64'd64);
      chk("cpol_rises", 64'(rises - s_rises), 64'd64);
      chk("cpol_sen0_low", 64'(sen0_low - s_sen0), 64'd132);
      chk("cpol_all_low", 64'(tot_low - s_tot), 64'd132);
      chk("cpol_runs", 64'(runs - s_runs), 64'd2);
      chk("cpol_idle_after", {63'd0, sclk}, 64'd1);
      rd_chk("cpol_pop0", RB + 8'd1, 64'h1_1234_5678);
      rd_chk("cpol_pop1", RB + 8'd1, 64'h1_9ABC_DEF0);
      rd_chk("cpol_status", RB, 64'd0);

      // Flush while a transaction is on the wire
      wr(SR, 32'd1);
      wr(SR + 8'd1, 32'h0001_0008);
      snap();
      wr(SR + 8'd2, 32'hFF00_0000);
      repeat (6) tick();
      wr(SR + 8'd3, 32'd0);
      repeat (60) tick();
      chk("flush_sen0_low", 64'(sen0_low - s_sen0), 64'd36);
      chk("flush_avail_never", 64'(avail_hi - s_avail), 64'd0);
      rd_chk("flush_status", RB, 64'd0);
      rd_chk("flush_pop", RB + 8'd1, 64'd0);

      // Reset during LEAD of bit 3
      wr(SR, 32'd3);
      wr(SR + 8'd1, 32'h0001_0008);
      snap();
      wr(SR + 8'd2, 32'hAA00_0000);
      repeat (30) tick();
      chk("abort_in_lead", {62'd0, sclk, sen[0]}, 64'd2);
      chk("abort_bit_index", 64'(rises - s_rises), 64'd4);
      reset = 1'b1;
      tick();
      chk("abort_sen", 64'(sen), 64'hFF);
      chk("abort_sclk_mosi", {62'd0, sclk, mosi}, 64'd0);
      reset = 1'b0;
      rd_chk("abort_status", RB, 64'd0);
      s_avail = avail_hi;
      repeat (60) tick();
      chk("abort_avail_never", 64'(avail_hi - s_avail), 64'd0);
      rd_chk("abort_pop", RB + 8'd1, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
